// File: rtl/hs_pkg.sv
// Shared definitions for the hs_* valid/ready buffer family.
package hs_pkg;

  localparam int HS_MIN_DEPTH = 2;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hs_buf_mem.sv
// WIDTH x DEPTH flop storage: registered write port, asynchronous read port.
module hs_buf_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Payload storage carries no reset; only the control state does.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer; every output is decoded from flops only.
module hs_elastic_buffer
  import hs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] hs_ptr_t;

  if (DEPTH < HS_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("hs_elastic_buffer: DEPTH must be a power of two >= %0d", HS_MIN_DEPTH);
  end

  hs_ptr_t       wr_ptr;
  hs_ptr_t       rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] next_count;
  logic          up_ready_q;
  logic          push;
  logic          pop;

  assign push       = up_valid && up_ready_q;
  assign pop        = down_valid && down_ready;
  assign down_valid = (count_q != '0);
  assign up_ready   = up_ready_q;
  assign count      = count_q;

  always_comb begin
    next_count = count_q;
    if (flush) begin
      next_count = '0;
    end else begin
      case ({push, pop})
        2'b10:   next_count = count_q + CW'(1);
        2'b01:   next_count = count_q - CW'(1);
        default: next_count = count_q;
      endcase
    end
  end

  // Ready is registered from next occupancy, so a full buffer stays closed
  // through a same-cycle pop and reopens one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      up_ready_q <= 1'b0;
    end else begin
      count_q    <= next_count;
      up_ready_q <= (next_count < CW'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + hs_ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + hs_ptr_t'(1);
      end
    end
  end

  // A beat accepted during flush is dropped rather than stored.
  hs_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (up_data),
    .raddr (rd_ptr),
    .rdata (down_data)
  );

endmodule
